// File: rtl/fetch_redirect_unit.sv
// IF-stage PC sequencer and IF/ID pipeline register.
// Redirects on ID branch decisions and drains fetches that are already outstanding.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_offset,
    input  logic [31:0] i_id_pc_plus4,
    input  logic        i_freeze,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_pc_plus4,
    output logic [31:0] o_if_instr,
    output logic        o_if_valid,
    output logic        o_flush
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc4;
    logic [31:0] r_if_pc_plus4;
    logic [31:0] r_if_instr;
    logic        r_if_valid;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_tgt_next;
    logic [31:0] w_buf_next;
    logic [31:0] w_buf_pc4_next;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic [31:0] w_deliver_pc4;

    assign w_target   = i_id_pc_plus4 + {i_branch_offset[29:0], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (i_imem_ready) begin
                    if (!i_branch_taken && i_freeze) begin
                        w_state_next = HELD;
                    end
                end else if (i_branch_taken) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (i_imem_ready) begin
                    w_state_next = FETCH;
                end
            end
            HELD: begin
                if (i_branch_taken || !i_freeze) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_comb begin
        o_imem_req = (r_state != HELD);
    end

    // While a request is outstanding the address must not move, so a redirect
    // seen mid-request is parked in r_tgt and applied once the stale word returns.
    always_comb begin
        w_pc_next       = r_pc;
        w_tgt_next      = r_tgt;
        w_buf_next      = r_buf;
        w_buf_pc4_next  = r_buf_pc4;
        w_deliver       = 1'b0;
        w_deliver_instr = 32'd0;
        w_deliver_pc4   = 32'd0;
        case (r_state)
            FETCH: begin
                if (i_imem_ready) begin
                    if (i_branch_taken) begin
                        w_pc_next = w_target;
                    end else if (i_freeze) begin
                        w_buf_next     = i_imem_rdata;
                        w_buf_pc4_next = w_pc_plus4;
                        w_pc_next      = w_pc_plus4;
                    end else begin
                        w_deliver       = 1'b1;
                        w_deliver_instr = i_imem_rdata;
                        w_deliver_pc4   = w_pc_plus4;
                        w_pc_next       = w_pc_plus4;
                    end
                end else if (i_branch_taken) begin
                    w_tgt_next = w_target;
                end
            end
            DRAIN: begin
                if (i_imem_ready) begin
                    w_pc_next = i_branch_taken ? w_target : r_tgt;
                end else if (i_branch_taken) begin
                    w_tgt_next = w_target;
                end
            end
            HELD: begin
                if (i_branch_taken) begin
                    w_pc_next = w_target;
                end else if (!i_freeze) begin
                    w_deliver       = 1'b1;
                    w_deliver_instr = r_buf;
                    w_deliver_pc4   = r_buf_pc4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc      <= RESET_PC;
            r_tgt     <= 32'd0;
            r_buf     <= 32'd0;
            r_buf_pc4 <= 32'd0;
        end else begin
            r_pc      <= w_pc_next;
            r_tgt     <= w_tgt_next;
            r_buf     <= w_buf_next;
            r_buf_pc4 <= w_buf_pc4_next;
        end
    end

    // A taken branch always bubbles IF/ID, even under freeze.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_if_pc_plus4 <= 32'd0;
            r_if_instr    <= 32'd0;
            r_if_valid    <= 1'b0;
        end else if (i_branch_taken) begin
            r_if_pc_plus4 <= 32'd0;
            r_if_instr    <= 32'd0;
            r_if_valid    <= 1'b0;
        end else if (!i_freeze) begin
            r_if_pc_plus4 <= w_deliver_pc4;
            r_if_instr    <= w_deliver_instr;
            r_if_valid    <= w_deliver;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_if_pc_plus4 = r_if_pc_plus4;
    assign o_if_instr    = r_if_instr;
    assign o_if_valid    = r_if_valid;
    assign o_flush       = i_branch_taken;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed testbench for fetch_redirect_unit; each task drives one scenario
// and compares against hand-computed values.
module tb_fetch_redirect_unit;

    logic        clk;
    logic        rst;
    logic        branchTaken;
    logic [31:0] branchOffset;
    logic [31:0] idPcPlus4;
    logic        freeze;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic [31:0] ifPcPlus4;
    logic [31:0] ifInstr;
    logic        ifValid;
    logic        flush;

    int total = 0;
    int bad   = 0;

    fetch_redirect_unit #(.RESET_PC(32'h0000_0100)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_branch_taken (branchTaken),
        .i_branch_offset(branchOffset),
        .i_id_pc_plus4  (idPcPlus4),
        .i_freeze       (freeze),
        .o_imem_req     (imemReq),
        .o_imem_addr    (imemAddr),
        .i_imem_ready   (imemReady),
        .i_imem_rdata   (imemRdata),
        .o_if_pc_plus4  (ifPcPlus4),
        .o_if_instr     (ifInstr),
        .o_if_valid     (ifValid),
        .o_flush        (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        branchTaken  = 1'b0;
        branchOffset = 32'd0;
        idPcPlus4    = 32'd0;
        freeze       = 1'b0;
        imemReady    = 1'b0;
        imemRdata    = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idleInputs();
        #12;
        total++; if (imemAddr !== 32'h100) begin bad++; $display("[TB] FAIL reset_addr got=%h want=%h", imemAddr, 32'h100); end
        total++; if (imemReq !== 1'b1) begin bad++; $display("[TB] FAIL reset_req got=%b want=1", imemReq); end
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", ifValid); end
        total++; if (ifInstr !== 32'd0) begin bad++; $display("[TB] FAIL reset_instr got=%h want=0", ifInstr); end
        total++; if (ifPcPlus4 !== 32'd0) begin bad++; $display("[TB] FAIL reset_pc4 got=%h want=0", ifPcPlus4); end
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush got=%b want=0", flush); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] expAddr;
        expAddr = 32'h100;
        imemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imemRdata = 32'hA000_0000 | expAddr;
            #1;
            total++; if (imemAddr !== expAddr) begin bad++; $display("[TB] FAIL seq_addr[%0d] got=%h want=%h", i, imemAddr, expAddr); end
            tick();
            total++; if (ifInstr !== (32'hA000_0000 | expAddr)) begin bad++; $display("[TB] FAIL seq_instr[%0d] got=%h want=%h", i, ifInstr, 32'hA000_0000 | expAddr); end
            total++; if (ifPcPlus4 !== expAddr + 32'd4) begin bad++; $display("[TB] FAIL seq_pc4[%0d] got=%h want=%h", i, ifPcPlus4, expAddr + 32'd4); end
            total++; if (ifValid !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid[%0d] got=%b want=1", i, ifValid); end
            expAddr = expAddr + 32'd4;
        end
        total++; if (imemAddr !== 32'h10C) begin bad++; $display("[TB] FAIL seq_final_addr got=%h want=%h", imemAddr, 32'h10C); end
    endtask

    task automatic test_branch();
        branchTaken  = 1'b1;
        idPcPlus4    = 32'h20;
        branchOffset = 32'hFFFF_FFFE;
        imemReady    = 1'b1;
        imemRdata    = 32'h5555_5555;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL br_flush got=%b want=1", flush); end
        tick();
        branchTaken = 1'b0;
        imemReady   = 1'b0;
        #1;
        total++; if (imemAddr !== 32'h18) begin bad++; $display("[TB] FAIL br_addr got=%h want=%h", imemAddr, 32'h18); end
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL br_valid got=%b want=0", ifValid); end
        total++; if (ifInstr !== 32'd0) begin bad++; $display("[TB] FAIL br_instr got=%h want=0", ifInstr); end
        total++; if (ifPcPlus4 !== 32'd0) begin bad++; $display("[TB] FAIL br_pc4 got=%h want=0", ifPcPlus4); end
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL br_flush_low got=%b want=0", flush); end
    endtask

    // pc is 0x18; redirect to 0x40 while the 0x18 fetch is stalled.
    task automatic test_drain();
        for (int c = 0; c < 3; c++) begin
            branchTaken  = (c == 0);
            idPcPlus4    = 32'h30;
            branchOffset = 32'd4;
            imemReady    = 1'b0;
            #1;
            total++; if (imemAddr !== 32'h18) begin bad++; $display("[TB] FAIL drain_addr[%0d] got=%h want=%h", c, imemAddr, 32'h18); end
            total++; if (imemReq !== 1'b1) begin bad++; $display("[TB] FAIL drain_req[%0d] got=%b want=1", c, imemReq); end
            tick();
            total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid[%0d] got=%b want=0", c, ifValid); end
        end
        branchTaken = 1'b0;
        imemReady   = 1'b1;
        imemRdata   = 32'hBAD0_BAD0;
        tick();
        imemReady = 1'b0;
        #1;
        total++; if (imemAddr !== 32'h40) begin bad++; $display("[TB] FAIL drain_redirect got=%h want=%h", imemAddr, 32'h40); end
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL drain_discard_valid got=%b want=0", ifValid); end
        total++; if (ifInstr !== 32'd0) begin bad++; $display("[TB] FAIL drain_discard_instr got=%h want=0", ifInstr); end
    endtask

    // Two redirects during one drain: the later target must win.
    task automatic test_drain_newest();
        branchTaken  = 1'b1;
        idPcPlus4    = 32'h50;
        branchOffset = 32'd4;
        imemReady    = 1'b0;
        tick();
        idPcPlus4 = 32'h70;
        tick();
        branchTaken = 1'b0;
        imemReady   = 1'b1;
        imemRdata   = 32'h1234_5678;
        #1;
        total++; if (imemAddr !== 32'h40) begin bad++; $display("[TB] FAIL newest_hold_addr got=%h want=%h", imemAddr, 32'h40); end
        tick();
        imemReady = 1'b0;
        #1;
        total++; if (imemAddr !== 32'h80) begin bad++; $display("[TB] FAIL newest_addr got=%h want=%h", imemAddr, 32'h80); end
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL newest_valid got=%b want=0", ifValid); end
    endtask

    task automatic test_freeze();
        imemReady = 1'b1;
        imemRdata = 32'h1111_1111;
        tick();
        freeze    = 1'b1;
        imemRdata = 32'hDEAD_BEEF;
        tick();
        imemReady = 1'b0;
        #1;
        total++; if (imemReq !== 1'b0) begin bad++; $display("[TB] FAIL frz_req got=%b want=0", imemReq); end
        total++; if (ifInstr !== 32'h1111_1111) begin bad++; $display("[TB] FAIL frz_hold_instr got=%h want=%h", ifInstr, 32'h1111_1111); end
        total++; if (ifPcPlus4 !== 32'h84) begin bad++; $display("[TB] FAIL frz_hold_pc4 got=%h want=%h", ifPcPlus4, 32'h84); end
        tick();
        total++; if (imemReq !== 1'b0) begin bad++; $display("[TB] FAIL frz_req2 got=%b want=0", imemReq); end
        total++; if (ifValid !== 1'b1) begin bad++; $display("[TB] FAIL frz_hold_valid got=%b want=1", ifValid); end
        freeze = 1'b0;
        tick();
        total++; if (ifInstr !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL frz_rel_instr got=%h want=%h", ifInstr, 32'hDEAD_BEEF); end
        total++; if (ifPcPlus4 !== 32'h88) begin bad++; $display("[TB] FAIL frz_rel_pc4 got=%h want=%h", ifPcPlus4, 32'h88); end
        total++; if (ifValid !== 1'b1) begin bad++; $display("[TB] FAIL frz_rel_valid got=%b want=1", ifValid); end
        total++; if (imemReq !== 1'b1) begin bad++; $display("[TB] FAIL frz_rel_req got=%b want=1", imemReq); end
        total++; if (imemAddr !== 32'h88) begin bad++; $display("[TB] FAIL frz_rel_addr got=%h want=%h", imemAddr, 32'h88); end
        imemReady = 1'b1;
        imemRdata = 32'h2222_2222;
        tick();
        total++; if (ifInstr !== 32'h2222_2222) begin bad++; $display("[TB] FAIL frz_resume_instr got=%h want=%h", ifInstr, 32'h2222_2222); end
        total++; if (ifPcPlus4 !== 32'h8C) begin bad++; $display("[TB] FAIL frz_resume_pc4 got=%h want=%h", ifPcPlus4, 32'h8C); end
    endtask

    task automatic test_freeze_branch();
        freeze       = 1'b1;
        branchTaken  = 1'b1;
        idPcPlus4    = 32'h200;
        branchOffset = 32'h10;
        imemReady    = 1'b1;
        imemRdata    = 32'h7777_7777;
        tick();
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL fb_valid got=%b want=0", ifValid); end
        total++; if (ifInstr !== 32'd0) begin bad++; $display("[TB] FAIL fb_instr got=%h want=0", ifInstr); end
        total++; if (imemAddr !== 32'h240) begin bad++; $display("[TB] FAIL fb_addr got=%h want=%h", imemAddr, 32'h240); end
        total++; if (imemReq !== 1'b1) begin bad++; $display("[TB] FAIL fb_req got=%b want=1", imemReq); end
        branchTaken = 1'b0;
        imemRdata   = 32'h3333_3333;
        tick();
        total++; if (imemReq !== 1'b0) begin bad++; $display("[TB] FAIL fb_held_req got=%b want=0", imemReq); end
        branchTaken  = 1'b1;
        idPcPlus4    = 32'h300;
        branchOffset = 32'd0;
        imemReady    = 1'b0;
        tick();
        total++; if (imemAddr !== 32'h300) begin bad++; $display("[TB] FAIL fb_held_addr got=%h want=%h", imemAddr, 32'h300); end
        total++; if (imemReq !== 1'b1) begin bad++; $display("[TB] FAIL fb_held_req2 got=%b want=1", imemReq); end
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL fb_held_valid got=%b want=0", ifValid); end
        branchTaken = 1'b0;
        freeze      = 1'b0;
        imemReady   = 1'b1;
        imemRdata   = 32'h0000_0044;
        tick();
        total++; if (ifInstr !== 32'h44) begin bad++; $display("[TB] FAIL fb_drop_instr got=%h want=%h", ifInstr, 32'h44); end
        total++; if (ifPcPlus4 !== 32'h304) begin bad++; $display("[TB] FAIL fb_drop_pc4 got=%h want=%h", ifPcPlus4, 32'h304); end
    endtask

    task automatic test_async_reset();
        branchTaken  = 1'b1;
        idPcPlus4    = 32'h500;
        branchOffset = 32'd0;
        imemReady    = 1'b0;
        tick();
        branchTaken = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (imemAddr !== 32'h100) begin bad++; $display("[TB] FAIL ar_addr got=%h want=%h", imemAddr, 32'h100); end
        total++; if (imemReq !== 1'b1) begin bad++; $display("[TB] FAIL ar_req got=%b want=1", imemReq); end
        total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL ar_valid got=%b want=0", ifValid); end
        tick();
        #2;
        rst = 1'b1;
        tick();
        imemReady = 1'b1;
        imemRdata = 32'hCAFE_0100;
        #1;
        total++; if (imemAddr !== 32'h100) begin bad++; $display("[TB] FAIL ar_restart_addr got=%h want=%h", imemAddr, 32'h100); end
        tick();
        total++; if (ifInstr !== 32'hCAFE_0100) begin bad++; $display("[TB] FAIL ar_instr got=%h want=%h", ifInstr, 32'hCAFE_0100); end
        total++; if (ifPcPlus4 !== 32'h104) begin bad++; $display("[TB] FAIL ar_pc4 got=%h want=%h", ifPcPlus4, 32'h104); end
        total++; if (imemAddr !== 32'h104) begin bad++; $display("[TB] FAIL ar_next_addr got=%h want=%h", imemAddr, 32'h104); end
        total++; if (ifValid !== 1'b1) begin bad++; $display("[TB] FAIL ar_valid2 got=%b want=1", ifValid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_drain();
        test_drain_newest();
        test_freeze();
        test_freeze_branch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
IF-stage PC sequencer and IF/ID pipeline register for the 5-stage core, and the consumer of the branch_taken decision made in ID. It issues instruction-memory requests over a req/ready handshake and captures fetched words into IF/ID. It also applies freeze from the hazard unit and, on branch_taken, redirects the PC to the branch target, squashing wrong-path fetches, including any access still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
branch_taken  in  1  ID-stage branch decision, valid every cycle
branch_offset  in  32  sign-extended word offset from ID
id_pc_plus4  in  32  PC+4 of the branch instruction in ID
freeze  in  1  hazard stall; hold IF/ID and stop PC advance
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address
imem_ready  in  1  memory completes the request this cycle; imem_rdata valid
imem_rdata  in  32  fetched instruction
if_pc_plus4  out  32  IF/ID register: PC+4 of held instruction
if_instr  out  32  IF/ID register: instruction (32'd0 = NOP)
if_valid  out  1  IF/ID register holds a real instruction
flush  out  1  combinational copy of branch_taken, clears ID/EX downstream

Behaviour:
- Reset (rst low, asynchronous): pc=RESET_PC, state=FETCH, tgt=0, buf=0, if_valid=0, if_instr=0, if_pc_plus4=0. Memory ignores req while rst is low.
- Target: target = id_pc_plus4 + (branch_offset << 2), modulo 2^32; wrap-around is silent.
- Handshake: imem_req=1 in FETCH and DRAIN, 0 in HELD. While req=1 and ready=0, imem_addr must stay stable. A transfer completes on any cycle with req and ready both high. imem_addr = pc in all states.
- IF/ID update priority each cycle:
  - branch_taken: load bubble (valid=0, instr=0, pc_plus4=0), even when freeze=1.
  - else freeze: hold.
  - else load the delivered instruction, or a bubble if none was delivered.
- FETCH:
  - ready & branch_taken: discard rdata; pc<=target; stay in FETCH.
  - ready & freeze: buf<=rdata, buf_pc4<=pc+4; pc<=pc+4; go to HELD.
  - ready otherwise: IF/ID<={pc+4, rdata, valid=1}; pc<=pc+4.
  - no ready & branch_taken: tgt<=target; go to DRAIN (the address may not change mid-request).
  - no ready otherwise: pc unchanged.
- DRAIN: the old request stays outstanding.
  - ready: discard rdata; pc<=tgt; go to FETCH.
  - Branch_taken during DRAIN overwrites tgt (newest wins).
  - Branch_taken coinciding with ready: pc<=new target.
- HELD:
  - branch_taken: drop buf; pc<=target; go to FETCH.
  - else !freeze: IF/ID<={buf_pc4, buf, 1}; go to FETCH.
  - else stay.
- Latency: a new instruction reaches IF/ID one cycle after its ready; the branch penalty is 1 bubble plus any drain cycles.
- flush = branch_taken, combinationally; no internal state.

Test Plan:
- Reset with RESET_PC=0x100 and ready always 1 -> imem_addr 0x100, 0x104, 0x108; if_instr follows rdata one cycle later; if_valid=1 from the 2nd cycle.
- branch_taken=1, id_pc_plus4=0x20, offset=0xFFFFFFFE with ready=1 -> next imem_addr 0x18; IF/ID bubble; flush=1 in the same cycle.
- Ready held low 3 cycles, branch_taken pulse in cycle 1 (target 0x40) -> imem_addr stays at the old pc until ready; that rdata is discarded; then imem_addr=0x40 and if_valid=0 throughout.
- freeze=1 when ready arrives with rdata=0xDEADBEEF -> state HELD, imem_req=0, IF/ID unchanged. Release freeze -> if_instr=0xDEADBEEF, valid=1, fetch resumes at pc+4.
- freeze=1 and branch_taken=1 together -> IF/ID bubble, pc=target; branch wins.
- Async rst low mid-DRAIN -> all outputs reset immediately, imem_addr=RESET_PC; after release fetch restarts cleanly.
